// File: rtl/currctrl_pkg.sv
// currctrl_pkg: shared FSM states, register RAM map and status word layout for the current-control scanner
package currctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, SP_OUT, WB, STAT} state_t;
  localparam logic [7:0] MAP_SP_BASE = 8'h00;
  localparam logic [7:0] MAP_MEAS_BASE = 8'h40;
  localparam logic [7:0] MAP_STAT_ADDR = 8'h7F;
  localparam int STAT_SCAN_LSB = 0;
  localparam int STAT_OVR_LSB = 16;
endpackage

// File: rtl/currctrl_meas_shadow.sv
// currctrl_meas_shadow: latest measured current per channel with combinational read
module currctrl_meas_shadow #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              meas_valid,
  input  logic [3:0]        meas_ch,
  input  logic [DATA_W-1:0] meas_data,
  input  logic [3:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data
);
  localparam logic [4:0] NC = 5'(NUM_CH);
  logic [DATA_W-1:0] mem [16];
  assign rd_data = mem[rd_ch];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (meas_valid && {1'b0, meas_ch} < NC) begin
      mem[meas_ch] <= meas_data;
    end
  end
endmodule

// File: rtl/currctrl_regram_scanner.sv
// currctrl_regram_scanner: cyclic setpoint read-out and telemetry write-back on register RAM port 2
module currctrl_regram_scanner
  import currctrl_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] SP_BASE = ADDR_W'(MAP_SP_BASE),
  parameter logic [ADDR_W-1:0] MEAS_BASE = ADDR_W'(MAP_MEAS_BASE),
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(MAP_STAT_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              sp_valid,
  input  logic              sp_ready,
  output logic [3:0]        sp_ch,
  output logic [DATA_W-1:0] sp_data,
  input  logic              meas_valid,
  input  logic [3:0]        meas_ch,
  input  logic [DATA_W-1:0] meas_data,
  output logic              overrun
);
  localparam logic [3:0] LAST = 4'(NUM_CH - 1);
  state_t state;
  logic [3:0] ch, rd_ch;
  logic [15:0] scan_cnt, ovr_cnt, ovr_nxt;
  logic [DATA_W-1:0] rd_data, wb_data, stat_w;
  logic ovr_hit;
  assign ram_byteenable = 4'hF;
  assign ram_clken = 1'b1;
  currctrl_meas_shadow #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) u_shadow (
    .clk(clk),
    .reset(reset),
    .meas_valid(meas_valid),
    .meas_ch(meas_ch),
    .meas_data(meas_data),
    .rd_ch(rd_ch),
    .rd_data(rd_data)
  );
  always_comb begin
    rd_ch = state == WB ? ch + 4'd1 : 4'd0;
    wb_data = meas_valid && meas_ch == rd_ch ? meas_data : rd_data;
    ovr_hit = start && busy;
    ovr_nxt = ovr_hit && ovr_cnt != 16'hFFFF ? ovr_cnt + 16'd1 : ovr_cnt;
    stat_w = '0;
    stat_w[STAT_OVR_LSB +: 16] = ovr_nxt;
    stat_w[STAT_SCAN_LSB +: 16] = scan_cnt + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      busy <= 1'b0;
      scan_cnt <= '0;
      ovr_cnt <= '0;
      overrun <= 1'b0;
      sp_valid <= 1'b0;
      sp_ch <= '0;
      sp_data <= '0;
      ram_address <= '0;
      ram_chipselect <= 1'b0;
      ram_write <= 1'b0;
      ram_writedata <= '0;
    end else begin
      ovr_cnt <= ovr_nxt;
      overrun <= overrun | ovr_hit;
      case (state)
        IDLE: if (start) begin
          state <= RD_ADDR;
          busy <= 1'b1;
          ch <= '0;
          ram_chipselect <= 1'b1;
          ram_write <= 1'b0;
          ram_address <= SP_BASE;
        end
        RD_ADDR: begin
          state <= RD_CAP;
          ram_chipselect <= 1'b0;
        end
        RD_CAP: begin
          state <= SP_OUT;
          sp_data <= ram_readdata;
          sp_ch <= ch;
          sp_valid <= 1'b1;
        end
        SP_OUT: if (sp_ready) begin
          sp_valid <= 1'b0;
          ram_chipselect <= 1'b1;
          if (ch == LAST) begin
            state <= WB;
            ch <= '0;
            ram_write <= 1'b1;
            ram_address <= MEAS_BASE;
            ram_writedata <= wb_data;
          end else begin
            state <= RD_ADDR;
            ch <= ch + 4'd1;
            ram_address <= SP_BASE + ADDR_W'(ch + 4'd1);
          end
        end
        WB: if (ch == LAST) begin
          state <= STAT;
          ram_address <= STAT_ADDR;
          ram_writedata <= stat_w;
        end else begin
          ch <= ch + 4'd1;
          ram_address <= MEAS_BASE + ADDR_W'(ch + 4'd1);
          ram_writedata <= wb_data;
        end
        STAT: begin
          state <= IDLE;
          busy <= 1'b0;
          ch <= '0;
          ram_chipselect <= 1'b0;
          ram_write <= 1'b0;
          scan_cnt <= scan_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_currctrl_regram_scanner.sv
// tb_currctrl_regram_scanner: randomized self-checking bench for the register RAM scanner
module tb_currctrl_regram_scanner;
  localparam logic [7:0] SPB = 8'h00;
  localparam logic [7:0] MB = 8'h40;
  localparam logic [7:0] SA = 8'h7F;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, ram_chipselect, ram_write, ram_clken, sp_valid, overrun;
  logic [7:0] ram_address;
  logic [3:0] ram_byteenable, sp_ch;
  logic [31:0] ram_writedata, ram_readdata, sp_data;
  logic sp_ready = 1'b0;
  logic meas_valid = 1'b0;
  logic [3:0] meas_ch = 4'd0;
  logic [31:0] meas_data = 32'd0;
  logic pl_en = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [7:0] addr_q = 8'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] mem [256];
  logic [31:0] m_sh [8];
  int total = 0;
  int passed = 0;
  logic [3:0] hs_ch [$];
  logic [31:0] hs_data [$];
  int hs_gap [$];
  int lat, unstable, stall_ram;
  bit timeout;

  always #5 clk = ~clk;

  currctrl_regram_scanner dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .ram_address(ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_write(ram_write),
    .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata),
    .ram_clken(ram_clken),
    .ram_readdata(ram_readdata),
    .sp_valid(sp_valid),
    .sp_ready(sp_ready),
    .sp_ch(sp_ch),
    .sp_data(sp_data),
    .meas_valid(meas_valid),
    .meas_ch(meas_ch),
    .meas_data(meas_data),
    .overrun(overrun)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_clken && ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++) if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
    if (ram_clken) addr_q <= ram_address;
  end
  assign ram_readdata = mem[addr_q];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    meas_valid = 1'b0;
    sp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_sh[i] = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_meas(input int c, input logic [31:0] d);
    meas_valid = 1'b1;
    meas_ch = 4'(c);
    meas_data = d;
    @(negedge clk);
    meas_valid = 1'b0;
    if (c < 8) m_sh[c] = d;
  endtask

  task automatic run_scan(input bit rnd, input int extra, input int coll_ch, input logic [31:0] coll_data, input int rst_ch);
    int k = 0;
    int last = 0;
    int left = extra;
    bit done = 0;
    bit held = 0;
    logic [3:0] h_ch = '0;
    logic [31:0] h_data = '0;
    hs_ch.delete();
    hs_data.delete();
    hs_gap.delete();
    lat = -1;
    unstable = 0;
    stall_ram = 0;
    start = 1'b1;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      meas_valid = 1'b0;
      if (left > 0 && k % 7 == 0) begin
        start = 1'b1;
        left--;
      end
      if (held && (!sp_valid || sp_ch !== h_ch || sp_data !== h_data)) unstable++;
      if (sp_valid && ram_chipselect) stall_ram++;
      if (sp_valid && lat < 0) lat = k;
      sp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = sp_valid && !sp_ready;
      h_ch = sp_ch;
      h_data = sp_data;
      if (sp_valid && sp_ready) begin
        hs_ch.push_back(sp_ch);
        hs_data.push_back(sp_data);
        hs_gap.push_back(k - last);
        last = k;
      end
      if (coll_ch >= 0 && ram_chipselect && ram_write && ram_address == MB + 8'(coll_ch)) begin
        meas_valid = 1'b1;
        meas_ch = 4'(coll_ch);
        meas_data = coll_data;
        m_sh[coll_ch] = coll_data;
      end
      if (rst_ch > 0 && ram_chipselect && ram_write && ram_address == MB + 8'(rst_ch - 1)) begin
        reset = 1'b1;
        done = 1;
      end
      if (!busy) done = 1;
    end
    timeout = !done;
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, sp_valid, ram_chipselect, ram_write, overrun} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, sp_valid, ram_chipselect, ram_write, overrun});
    else passed++;
    total++;
    if (ram_byteenable !== 4'hF || ram_clken !== 1'b1)
      $display("FAIL reset_const: got be=%h clken=%b want be=f clken=1", ram_byteenable, ram_clken);
    else passed++;
    total++;
    if (ram_address !== 8'h00 || sp_data !== 32'h0 || sp_ch !== 4'h0 || ram_writedata !== 32'h0)
      $display("FAIL reset_data: got addr=%h sp=%h ch=%h wd=%h want all zero", ram_address, sp_data, sp_ch, ram_writedata);
    else passed++;
  endtask

  task automatic test_latency();
    do_reset();
    for (int n = 0; n < 8; n++) preload(SPB + 8'(n), 32'h1000 + n);
    run_scan(1'b0, 0, -1, '0, -1);
    total++;
    if (timeout) $display("FAIL lat_timeout: got busy stuck want scan end"); else passed++;
    total++;
    if (lat !== 3) $display("FAIL lat_first_valid: got %0d want 3", lat); else passed++;
    total++;
    if (hs_ch.size() !== 8) $display("FAIL lat_count: got %0d want 8", hs_ch.size()); else passed++;
    for (int n = 0; n < hs_ch.size() && n < 8; n++) begin
      total++;
      if (hs_ch[n] !== 4'(n) || hs_data[n] !== 32'h1000 + n)
        $display("FAIL lat_sp%0d: got ch=%h data=%h want ch=%h data=%h", n, hs_ch[n], hs_data[n], 4'(n), 32'h1000 + n);
      else passed++;
      total++;
      if (hs_gap[n] !== 3) $display("FAIL lat_gap%0d: got %0d want 3", n, hs_gap[n]); else passed++;
    end
  endtask

  task automatic test_random_stall();
    logic [31:0] exp [8];
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 8; n++) begin
        exp[n] = $urandom;
        preload(SPB + 8'(n), exp[n]);
      end
      run_scan(1'b1, 0, -1, '0, -1);
      total++;
      if (timeout || hs_ch.size() !== 8)
        $display("FAIL stall_count%0d: got %0d handshakes timeout=%b want 8", r, hs_ch.size(), timeout);
      else passed++;
      for (int n = 0; n < hs_ch.size() && n < 8; n++) begin
        total++;
        if (hs_ch[n] !== 4'(n) || hs_data[n] !== exp[n])
          $display("FAIL stall_sp%0d_%0d: got ch=%h data=%h want ch=%h data=%h", r, n, hs_ch[n], hs_data[n], 4'(n), exp[n]);
        else passed++;
      end
      total++;
      if (unstable !== 0) $display("FAIL stall_stable%0d: got %0d changes want 0", r, unstable); else passed++;
      total++;
      if (stall_ram !== 0) $display("FAIL stall_ram%0d: got %0d accesses want 0", r, stall_ram); else passed++;
    end
  endtask

  task automatic test_meas_writeback();
    do_reset();
    for (int n = 0; n < 8; n++) drive_meas(n, $urandom);
    drive_meas(3, 32'hABCD);
    drive_meas(12, $urandom);
    run_scan(1'b0, 0, -1, '0, -1);
    total++;
    if (mem[MB + 8'd3] !== 32'hABCD) $display("FAIL wb_ch3: got %h want 0000abcd", mem[MB + 8'd3]); else passed++;
    for (int n = 0; n < 8; n++) begin
      total++;
      if (mem[MB + 8'(n)] !== m_sh[n]) $display("FAIL wb_ch%0d: got %h want %h", n, mem[MB + 8'(n)], m_sh[n]); else passed++;
    end
    total++;
    if (mem[SA] !== 32'h0000_0001) $display("FAIL wb_status: got %h want 00000001", mem[SA]); else passed++;
  endtask

  task automatic test_collision();
    do_reset();
    for (int n = 0; n < 8; n++) drive_meas(n, $urandom);
    drive_meas(2, 32'h1111);
    run_scan(1'b0, 0, 2, 32'h5555, -1);
    total++;
    if (mem[MB + 8'd2] !== 32'h1111) $display("FAIL coll_first: got %h want 00001111", mem[MB + 8'd2]); else passed++;
    run_scan(1'b0, 0, -1, '0, -1);
    total++;
    if (mem[MB + 8'd2] !== 32'h5555) $display("FAIL coll_second: got %h want 00005555", mem[MB + 8'd2]); else passed++;
    for (int n = 0; n < 8; n++) begin
      total++;
      if (mem[MB + 8'(n)] !== m_sh[n]) $display("FAIL coll_ch%0d: got %h want %h", n, mem[MB + 8'(n)], m_sh[n]); else passed++;
    end
    total++;
    if (mem[SA] !== 32'h0000_0002) $display("FAIL coll_status: got %h want 00000002", mem[SA]); else passed++;
  endtask

  task automatic test_overrun();
    int spurious = 0;
    do_reset();
    run_scan(1'b0, 2, -1, '0, -1);
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
    total++;
    if (mem[SA] !== 32'h0002_0001) $display("FAIL ovr_status: got %h want 00020001", mem[SA]); else passed++;
    total++;
    if (hs_ch.size() !== 8) $display("FAIL ovr_count: got %0d want 8", hs_ch.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) spurious++;
    end
    total++;
    if (spurious !== 0) $display("FAIL ovr_no_restart: got %0d busy cycles want 0", spurious); else passed++;
    run_scan(1'b0, 0, -1, '0, -1);
    total++;
    if (mem[SA] !== 32'h0002_0002) $display("FAIL ovr_status2: got %h want 00020002", mem[SA]); else passed++;
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
  endtask

  task automatic test_reset_mid_wb();
    logic [31:0] ch3;
    do_reset();
    for (int n = 4; n < 8; n++) preload(MB + 8'(n), 32'hDEAD_0000 + n);
    preload(SA, 32'hDEAD_BEEF);
    for (int n = 0; n < 8; n++) drive_meas(n, $urandom);
    ch3 = m_sh[3];
    run_scan(1'b0, 0, -1, '0, 4);
    @(negedge clk);
    total++;
    if ({busy, ram_chipselect, ram_write, sp_valid} !== 4'b0)
      $display("FAIL rst_mid_flags: got %b want 0000", {busy, ram_chipselect, ram_write, sp_valid});
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_sh[i] = '0;
    repeat (3) @(negedge clk);
    total++;
    if (mem[MB + 8'd3] !== ch3) $display("FAIL rst_mid_ch3: got %h want %h", mem[MB + 8'd3], ch3); else passed++;
    for (int n = 4; n < 8; n++) begin
      total++;
      if (mem[MB + 8'(n)] !== 32'hDEAD_0000 + n)
        $display("FAIL rst_mid_ch%0d: got %h want %h", n, mem[MB + 8'(n)], 32'hDEAD_0000 + n);
      else passed++;
    end
    total++;
    if (mem[SA] !== 32'hDEAD_BEEF) $display("FAIL rst_mid_status: got %h want deadbeef", mem[SA]); else passed++;
    run_scan(1'b0, 0, -1, '0, -1);
    total++;
    if (mem[SA] !== 32'h0000_0001) $display("FAIL rst_after_status: got %h want 00000001", mem[SA]); else passed++;
    total++;
    if (mem[MB + 8'd4] !== 32'h0) $display("FAIL rst_after_shadow: got %h want 00000000", mem[MB + 8'd4]); else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_random_stall();
    test_meas_writeback();
    test_collision();
    test_overrun();
    test_reset_mid_wb();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
